lcd_fill_ctrl: RTL

Rectangle-fill controller and access arbiter for the SPI LCD block. On `start` it issues the LCD transactions for a filled rectangle: column window, page window, memory write, then W×H pixels of one colour. The transactions are 0x2A, D16 x0, D16 x1, 0x2B, D16 y0, D16 y1, 0x2C, then colour repeated W×H times. When the engine is idle, it forwards CPU load strobes straight to the LCD, so software keeps direct access.

---
 rtl/lcd_fill_ctrl.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_fill_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_fill_ctrl
//
// Rectangle-fill engine and access arbiter in front of the SPI LCD block.
// On a valid start it issues, one load at a time and paced by lcdBusy:
//   C 0x2A, D16 x0, D16 x1, C 0x2B, D16 y0, D16 y1, C 0x2C,
// then D16 color once per pixel (W*H times). While idle, CPU strobes and data
// pass straight through to the LCD.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   start, abort               fill request (coords sampled same edge), stop
//   x0, x1, y0, y1 [CW]        inclusive rectangle corners
//   color [16]                 RGB565 fill value
//   busy, done, err            engine owns LCD / fill-complete / rejected pulses
//   cpu_loadC/D8/D16, cpu_in   CPU-side LCD strobes and data
//   lcd_busy                   LCD shift in progress
//   lcd_loadC/D8/D16, lcd_in   strobes and data to the LCD
// ---------------------------------------------------------------------------
module lcd_fill_ctrl #(
    parameter int CW = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] x0,
    input  logic [CW-1:0] x1,
    input  logic [CW-1:0] y0,
    input  logic [CW-1:0] y1,
    input  logic [15:0]   color,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic          cpu_loadC,
    input  logic          cpu_loadD8,
    input  logic          cpu_loadD16,
    input  logic [15:0]   cpu_in,
    input  logic          lcd_busy,
    output logic          lcd_loadC,
    output logic          lcd_loadD8,
    output logic          lcd_loadD16,
    output logic [15:0]   lcd_in
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PIXEL = 2'd2,
        ERR   = 2'd3
    } stateT;

    stateT         stateReg,  stateNext;
    logic [2:0]    stepReg,   stepNext;
    logic [CW-1:0] colReg,    colNext;
    logic [CW-1:0] rowReg,    rowNext;
    logic [CW-1:0] x0Reg,     x0Next;
    logic [CW-1:0] x1Reg,     x1Next;
    logic [CW-1:0] y0Reg,     y0Next;
    logic [CW-1:0] y1Reg,     y1Next;
    logic [15:0]   colorReg,  colorNext;
    logic          ldCReg,    ldCNext;
    logic          ldD16Reg,  ldD16Next;
    logic [15:0]   dataReg,   dataNext;
    logic          lastReg,   lastNext;
    logic          doneReg,   doneNext;

    logic          canIssue;
    logic          cpuAny;

    function automatic logic [15:0] zext(input logic [CW-1:0] v);
        logic [15:0] r;
        r        = '0;
        r[CW-1:0] = v;
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= IDLE;
            stepReg  <= '0;
            colReg   <= '0;
            rowReg   <= '0;
            x0Reg    <= '0;
            x1Reg    <= '0;
            y0Reg    <= '0;
            y1Reg    <= '0;
            colorReg <= '0;
            ldCReg   <= 1'b0;
            ldD16Reg <= 1'b0;
            dataReg  <= '0;
            lastReg  <= 1'b0;
            doneReg  <= 1'b0;
        end else begin
            stateReg <= stateNext;
            stepReg  <= stepNext;
            colReg   <= colNext;
            rowReg   <= rowNext;
            x0Reg    <= x0Next;
            x1Reg    <= x1Next;
            y0Reg    <= y0Next;
            y1Reg    <= y1Next;
            colorReg <= colorNext;
            ldCReg   <= ldCNext;
            ldD16Reg <= ldD16Next;
            dataReg  <= dataNext;
            lastReg  <= lastNext;
            doneReg  <= doneNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        stepNext  = stepReg;
        colNext   = colReg;
        rowNext   = rowReg;
        x0Next    = x0Reg;
        x1Next    = x1Reg;
        y0Next    = y0Reg;
        y1Next    = y1Reg;
        colorNext = colorReg;
        ldCNext   = 1'b0;
        ldD16Next = 1'b0;
        dataNext  = dataReg;
        lastNext  = lastReg;
        doneNext  = 1'b0;

        // A strobe that is visible right now has not yet raised lcd_busy, so
        // it also blocks the next issue. lastReg holds off issue while the
        // final pixel strobe is on the wire.
        canIssue = !lcd_busy && !ldCReg && !ldD16Reg && !lastReg;
        cpuAny   = cpu_loadC || cpu_loadD8 || cpu_loadD16;

        case (stateReg)
            IDLE: begin
                if (start) begin
                    if ((x1 < x0) || (y1 < y0)) begin
                        stateNext = ERR;
                    end else begin
                        x0Next    = x0;
                        x1Next    = x1;
                        y0Next    = y0;
                        y1Next    = y1;
                        colorNext = color;
                        colNext   = x0;
                        rowNext   = y0;
                        stepNext  = 3'd0;
                        stateNext = SETUP;
                        // Issue the first command on the start edge when the
                        // LCD is free and the CPU is not loading this cycle;
                        // otherwise step 0 waits for lcd_busy in SETUP.
                        if (!lcd_busy && !cpuAny) begin
                            ldCNext  = 1'b1;
                            dataNext = 16'h002A;
                            stepNext = 3'd1;
                        end
                    end
                end
            end

            // err is decoded from this state; busy stays low since the engine
            // never touches the LCD here.
            ERR: begin
                stateNext = IDLE;
            end

            SETUP: begin
                if (abort) begin
                    stateNext = IDLE;
                end else if (canIssue) begin
                    case (stepReg)
                        3'd0: begin ldCNext   = 1'b1; dataNext = 16'h002A;     end
                        3'd1: begin ldD16Next = 1'b1; dataNext = zext(x0Reg);  end
                        3'd2: begin ldD16Next = 1'b1; dataNext = zext(x1Reg);  end
                        3'd3: begin ldCNext   = 1'b1; dataNext = 16'h002B;     end
                        3'd4: begin ldD16Next = 1'b1; dataNext = zext(y0Reg);  end
                        3'd5: begin ldD16Next = 1'b1; dataNext = zext(y1Reg);  end
                        default: begin ldCNext = 1'b1; dataNext = 16'h002C;    end
                    endcase
                    if (stepReg >= 3'd6) begin
                        stateNext = PIXEL;
                    end else begin
                        stepNext = stepReg + 3'd1;
                    end
                end
            end

            PIXEL: begin
                if (abort) begin
                    stateNext = IDLE;
                    lastNext  = 1'b0;
                end else if (lastReg) begin
                    // Final pixel strobe is being sampled this edge.
                    stateNext = IDLE;
                    lastNext  = 1'b0;
                    doneNext  = 1'b1;
                end else if (canIssue) begin
                    ldD16Next = 1'b1;
                    dataNext  = colorReg;
                    if (colReg == x1Reg) begin
                        colNext = x0Reg;
                        if (rowReg == y1Reg) begin
                            lastNext = 1'b1;
                        end else begin
                            rowNext = rowReg + 1'b1;
                        end
                    end else begin
                        colNext = colReg + 1'b1;
                    end
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Output mux keys off the state register, so an asynchronous reset hands
    // the LCD back to the CPU without waiting for a clock edge.
    always_comb begin
        busy = (stateReg == SETUP) || (stateReg == PIXEL);
        done = doneReg;
        err  = (stateReg == ERR);
        if (stateReg == IDLE) begin
            lcd_loadC   = cpu_loadC;
            lcd_loadD8  = cpu_loadD8;
            lcd_loadD16 = cpu_loadD16;
            lcd_in      = cpu_in;
        end else begin
            lcd_loadC   = ldCReg;
            lcd_loadD8  = 1'b0;
            lcd_loadD16 = ldD16Reg;
            lcd_in      = dataReg;
        end
    end

endmodule
